// File: rtl/mips_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mips_issue_ctrl
//
// Issue sequencer in front of the multi-cycle MIPS execution core. It buffers
// instruction/output_reg pairs in a small FIFO and issues them one at a time to
// the core, with exactly one instruction in flight. The core has a variable
// latency (the GCD path can take many cycles). Each result goes back to the
// requester through a ready/valid response port.
//
// A watchdog bounds the time spent waiting for the core. If the core stays
// silent for TIMEOUT cycles, the block returns a timeout response. Once that
// response is accepted, the block parks in HALT until the next reset.
//
// Parameters
//   DEPTH    FIFO entries (power of 2, >= 2)
//   TIMEOUT  max cycles spent waiting for the core before the watchdog fires
//   CNT_W    width of the saturating statistics counters
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_ready = !full && !HALT
//   req_instr, req_oreg         instruction word and output_reg selector
//   core_in_valid               one-cycle issue pulse to the core
//   core_instruction/_output_reg FIFO head, driven while core_in_valid
//   core_out_valid, core_fail   core result strobe and instruction_fail flag
//   core_out                    {out_4,out_3,out_2,out_1} from the core
//   rsp_valid/rsp_ready         response handshake, response held until taken
//   rsp_data                    captured core_out (0 on fail or timeout)
//   rsp_fail, rsp_timeout       core failure / watchdog flags for the response
//   halted                      block is parked after a watchdog timeout
//   issue_cnt, fail_cnt         saturating statistics counters
// -----------------------------------------------------------------------------
module mips_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_instr,
  input  logic [19:0]      req_oreg,
  output logic             core_in_valid,
  output logic [31:0]      core_instruction,
  output logic [19:0]      core_output_reg,
  input  logic             core_out_valid,
  input  logic             core_fail,
  input  logic [63:0]      core_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_fail,
  output logic             rsp_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    HALT
  } state_t;

  state_t state;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [51:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic          full;
  logic          push;
  logic          pop;
  logic [51:0]   head;

  // Same-cycle push at full is refused even if a pop happens in that cycle.
  // Masking with rst keeps a request offered during reset from looking
  // accepted.
  assign full      = (count == FULL_CNT);
  assign req_ready = !rst && !full && (state != HALT);
  assign push      = req_valid && req_ready;
  assign pop       = (state == ISSUE);
  assign head      = fifo_mem[rd_ptr];

  // Core-facing and status outputs decode straight from the state register.
  // That keeps core_in_valid glitch-free and confined to ISSUE.
  assign core_in_valid    = (state == ISSUE);
  assign core_instruction = core_in_valid ? head[51:20] : '0;
  assign core_output_reg  = core_in_valid ? head[19:0]  : '0;
  assign rsp_valid        = (state == RESP);
  assign halted           = (state == HALT);

  // ---- request FIFO: storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_instr, req_oreg};
    end
  end

  // ---- request FIFO: pointers and occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // ---- issue / wait / respond sequencer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      rsp_data    <= '0;
      rsp_fail    <= 1'b0;
      rsp_timeout <= 1'b0;
      issue_cnt   <= '0;
      fail_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          issue_cnt <= sat_inc(issue_cnt);
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // A real result beats the watchdog when both land in the same cycle.
          if (core_out_valid) begin
            rsp_data    <= core_fail ? '0 : core_out;
            rsp_fail    <= core_fail;
            rsp_timeout <= 1'b0;
            if (core_fail) begin
              fail_cnt <= sat_inc(fail_cnt);
            end
            state <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_data    <= '0;
            rsp_fail    <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= rsp_timeout ? HALT : IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_issue_ctrl
//
// Self-checking bench for mips_issue_ctrl. A behavioural model tracks the
// queue of accepted requests, the instruction in flight and its response. It
// derives timing from the latency rules:
//   - an entry issues at max(accept + 2, previous handshake + 2);
//   - a response appears the cycle after the core answers, or after TIMEOUT
//     silent cycles.
// A bench-side core answers each issue after a chosen latency.
// -----------------------------------------------------------------------------
module tb_mips_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_instr;
  logic [19:0]      req_oreg;
  logic             core_in_valid;
  logic [31:0]      core_instruction;
  logic [19:0]      core_output_reg;
  logic             core_out_valid;
  logic             core_fail;
  logic [63:0]      core_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic             rsp_fail;
  logic             rsp_timeout;
  logic             halted;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] fail_cnt;

  mips_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_instr        (req_instr),
    .req_oreg         (req_oreg),
    .core_in_valid    (core_in_valid),
    .core_instruction (core_instruction),
    .core_output_reg  (core_output_reg),
    .core_out_valid   (core_out_valid),
    .core_fail        (core_fail),
    .core_out         (core_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_fail         (rsp_fail),
    .rsp_timeout      (rsp_timeout),
    .halted           (halted),
    .issue_cnt        (issue_cnt),
    .fail_cnt         (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [19:0] oreg;
    int          acc;
  } req_t;

  typedef struct {
    int          lat;
    bit          fail;
    logic [63:0] data;
  } core_t;

  typedef struct {
    logic [63:0] data;
    bit          fail;
    bit          to;
  } hs_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // behavioural model
  req_t        mq[$];
  bit          inflight_m = 0;
  bit          captured_m = 0;
  bit          halted_m   = 0;
  int          issue_m_cyc = 0;
  int          last_hs    = -100;
  int          issued_m   = 0;
  int          fails_m    = 0;
  logic [63:0] rsp_data_m = '0;
  bit          rsp_fail_m = 0;
  bit          rsp_to_m   = 0;

  // bench-side core
  core_t       core_q[$];
  int          core_resp_at = -1;
  bit          core_fail_r  = 0;
  logic [63:0] core_data_r  = '0;
  bit          rand_fail_en = 0;

  // stimulus requested for the next cycle
  bit          s_rst = 1;
  bit          s_req_valid = 0;
  bit          s_rsp_ready = 1;
  bit          s_stray = 0;
  logic [31:0] s_instr = '0;
  logic [19:0] s_oreg = '0;

  // observations for the literal expectations
  bit  last_acc = 0;
  bit  prev_rv = 0;
  int  obs_issue_cyc = -1;
  int  obs_rsp_first = -1;
  int  obs_core_resp = -1;
  hs_t hs_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    inflight_m = 0;
    captured_m = 0;
    halted_m   = 0;
    last_hs    = -100;
    issued_m   = 0;
    fails_m    = 0;
    last_acc   = 0;
    prev_rv    = 0;
  endtask

  // Compare every DUT output against the model, then advance the model.
  task automatic eval_cycle();
    bit    exp_issue;
    bit    exp_rdy;
    bit    exp_rv;
    core_t c;
    hs_t   h;
    exp_issue = !halted_m && !inflight_m && (mq.size() > 0) &&
                (cyc >= mq[0].acc + 2) && (cyc >= last_hs + 2);
    exp_rdy   = !halted_m && (mq.size() < DEPTH);
    exp_rv    = inflight_m && captured_m;

    check("core_in_valid", 64'(core_in_valid), 64'(exp_issue));
    if (exp_issue) begin
      check("core_instruction", 64'(core_instruction), 64'(mq[0].instr));
      check("core_output_reg", 64'(core_output_reg), 64'(mq[0].oreg));
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check("rsp_data", rsp_data, rsp_data_m);
      check("rsp_fail", 64'(rsp_fail), 64'(rsp_fail_m));
      check("rsp_timeout", 64'(rsp_timeout), 64'(rsp_to_m));
    end
    check("halted", 64'(halted), 64'(halted_m));
    check("issue_cnt", 64'(issue_cnt), 64'(issued_m));
    check("fail_cnt", 64'(fail_cnt), 64'(fails_m));

    // observations and bench core reaction
    if (rsp_valid && !prev_rv) obs_rsp_first = cyc;
    prev_rv = rsp_valid;
    if (cyc == core_resp_at) obs_core_resp = cyc;
    if (rsp_valid && rsp_ready) begin
      h.data = rsp_data;
      h.fail = rsp_fail;
      h.to   = rsp_timeout;
      hs_log.push_back(h);
    end
    if (core_in_valid) begin
      obs_issue_cyc = cyc;
      if (core_q.size() > 0) begin
        c = core_q.pop_front();
      end else begin
        c.lat  = $urandom_range(1, 50);
        c.fail = rand_fail_en && (($urandom % 4) == 0);
        c.data = {$urandom, $urandom};
      end
      core_resp_at = (c.lat > 0) ? cyc + c.lat : -1;
      core_fail_r  = c.fail;
      core_data_r  = c.data;
    end

    // model update
    if (exp_rv && rsp_ready) begin
      inflight_m = 0;
      captured_m = 0;
      last_hs    = cyc;
      if (rsp_to_m) halted_m = 1;
    end else if (inflight_m && !captured_m && cyc > issue_m_cyc) begin
      if (core_out_valid) begin
        captured_m = 1;
        rsp_fail_m = core_fail;
        rsp_data_m = core_fail ? 64'h0 : core_out;
        rsp_to_m   = 0;
        if (core_fail && fails_m < CNT_MAX) fails_m++;
      end else if (cyc == issue_m_cyc + TIMEOUT) begin
        captured_m = 1;
        rsp_fail_m = 0;
        rsp_data_m = 64'h0;
        rsp_to_m   = 1;
      end
    end
    if (exp_issue) begin
      issue_m_cyc = cyc;
      inflight_m  = 1;
      captured_m  = 0;
      void'(mq.pop_front());
      if (issued_m < CNT_MAX) issued_m++;
    end
    last_acc = req_valid && exp_rdy;
    if (last_acc) mq.push_back('{req_instr, req_oreg, cyc});
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst       = s_rst;
    req_valid = s_req_valid;
    req_instr = s_instr;
    req_oreg  = s_oreg;
    rsp_ready = s_rsp_ready;
    if (cyc == core_resp_at) begin
      core_out_valid = 1'b1;
      core_fail      = core_fail_r;
      core_out       = core_data_r;
    end else if (s_stray && !(inflight_m && !captured_m)) begin
      core_out_valid = 1'b1;
      core_fail      = 1'($urandom);
      core_out       = {$urandom, $urandom};
    end else begin
      core_out_valid = 1'b0;
      core_fail      = 1'b0;
      core_out       = '0;
    end
    @(negedge clk);
    if (rst) model_reset();
    else eval_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [19:0] oreg);
    bit ok;
    ok          = 0;
    s_req_valid = 1;
    s_instr     = instr;
    s_oreg      = oreg;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = last_acc;
    end
    s_req_valid = 0;
    check("push_accepted", 64'(ok), 64'(1));
  endtask

  task automatic drain();
    bit done;
    s_req_valid = 0;
    s_rsp_ready = 1;
    s_stray     = 0;
    for (int i = 0; i < 3000 && (mq.size() > 0 || inflight_m); i++) step();
    done = (mq.size() == 0) && !inflight_m;
    check("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int t_acc;
    int n_acc;
    bit seen;
    rst = 1'b1;
    req_valid = 1'b0;
    req_instr = '0;
    req_oreg = '0;
    rsp_ready = 1'b1;
    core_out_valid = 1'b0;
    core_fail = 1'b0;
    core_out = '0;

    // reset
    s_rst = 1;
    run(2);
    s_rst = 0;
    step();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_rsp_flags", 64'({rsp_fail, rsp_timeout, halted}), 64'(0));
    check("rst_core_in_valid", 64'(core_in_valid), 64'(0));
    check("rst_issue_cnt", 64'(issue_cnt), 64'(0));

    // single addi, 1-cycle core
    core_q.push_back('{1, 1'b0, 64'h5});
    obs_issue_cyc = -1;
    obs_rsp_first = -1;
    hs_log.delete();
    push_one(32'h22320005, 20'h0);
    t_acc = cyc;
    drain();
    check("addi_issue_latency", 64'(obs_issue_cyc - t_acc), 64'(2));
    check("addi_rsp_latency", 64'(obs_rsp_first - obs_core_resp), 64'(1));
    check("addi_rsp_data", hs_log[0].data, 64'h5);
    check("addi_rsp_fail", 64'(hs_log[0].fail), 64'(0));
    check("addi_issue_cnt", 64'(issue_cnt), 64'(1));

    // FIFO full / backpressure
    s_rsp_ready = 0;
    n_acc = 0;
    s_req_valid = 1;
    s_instr = 32'hA000_0000;
    s_oreg = 20'h0;
    for (int i = 0; i < 14 && n_acc < 6; i++) begin
      step();
      if (last_acc) begin
        n_acc++;
        s_instr = 32'hA000_0000 + 32'(n_acc);
        s_oreg  = 20'(n_acc);
      end
    end
    check("bp_accepted", 64'(n_acc), 64'(5));
    check("bp_req_ready_low", 64'(req_ready), 64'(0));
    s_rsp_ready = 1;
    for (int i = 0; i < 200 && n_acc < 6; i++) begin
      step();
      if (last_acc) n_acc++;
    end
    s_req_valid = 0;
    check("bp_sixth_accepted", 64'(n_acc), 64'(6));
    drain();

    // fail path, then a normal instruction behind it
    core_q.push_back('{3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    core_q.push_back('{2, 1'b0, 64'h1234});
    hs_log.delete();
    push_one(32'h0000_0001, 20'h1);
    push_one(32'h0000_0002, 20'h2);
    drain();
    check("fail_rsp_fail", 64'(hs_log[0].fail), 64'(1));
    check("fail_rsp_data", hs_log[0].data, 64'h0);
    check("fail_cnt", 64'(fail_cnt), 64'(1));
    check("after_fail_data", hs_log[1].data, 64'h1234);

    // long GCD latency and a response on the last watchdog cycle
    core_q.push_back('{40, 1'b0, 64'h40});
    core_q.push_back('{TIMEOUT, 1'b0, 64'hCAFE});
    hs_log.delete();
    push_one(32'h1000_0000, 20'h3);
    push_one(32'h1000_0001, 20'h4);
    drain();
    check("lat40_timeout", 64'(hs_log[0].to), 64'(0));
    check("lat40_data", hs_log[0].data, 64'h40);
    check("edge_timeout", 64'(hs_log[1].to), 64'(0));
    check("edge_data", hs_log[1].data, 64'hCAFE);

    // randomized traffic
    rand_fail_en = 1;
    for (int i = 0; i < 600; i++) begin
      s_req_valid = 1'($urandom % 2);
      s_instr     = $urandom;
      s_oreg      = 20'($urandom);
      s_rsp_ready = ($urandom % 4) != 0;
      s_stray     = ($urandom % 6) == 0;
      step();
    end
    rand_fail_en = 0;
    drain();

    // reset mid-WAIT with three entries queued
    core_q.push_back('{30, 1'b0, 64'hDEAD});
    for (int i = 0; i < 4; i++) push_one(32'h2000_0000 + 32'(i), 20'(i));
    run(3);
    s_rst = 1;
    step();
    s_rst = 0;
    obs_rsp_first = -1;
    step();
    check("mid_rst_req_ready", 64'(req_ready), 64'(1));
    check("mid_rst_issue_cnt", 64'(issue_cnt), 64'(0));
    check("mid_rst_fail_cnt", 64'(fail_cnt), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    run(40);
    seen = (obs_rsp_first != -1);
    check("late_core_ignored", 64'(seen), 64'(0));
    core_q.push_back('{2, 1'b0, 64'h77});
    hs_log.delete();
    push_one(32'h3000_0000, 20'h5);
    drain();
    check("post_rst_data", hs_log[0].data, 64'h77);

    // watchdog: the core never answers
    core_q.push_back('{0, 1'b0, 64'h0});
    hs_log.delete();
    push_one(32'h4000_0000, 20'h6);
    drain();
    check("wd_rsp_timeout", 64'(hs_log[0].to), 64'(1));
    check("wd_rsp_data", hs_log[0].data, 64'h0);
    step();
    check("wd_halted", 64'(halted), 64'(1));
    check("wd_req_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 30; i++) begin
      s_req_valid = 1;
      s_instr     = $urandom;
      s_stray     = ($urandom % 3) == 0;
      step();
    end
    s_req_valid = 0;
    s_stray = 0;
    check("wd_still_halted", 64'(halted), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
